// File: rtl/hilo_muldiv_if.sv
// Request/response bundle between decode/execute and the HI/LO mul/div unit.
// master drives requests and MT* writes, slave returns busy/done and HI/LO.
interface hilo_muldiv_if #(
    parameter int WIDTH = 32
);
    logic             i_valid;
    logic             i_div;
    logic             i_sign;
    logic [WIDTH-1:0] i_src1;
    logic [WIDTH-1:0] i_src2;
    logic             i_hi_we;
    logic             i_lo_we;
    logic [WIDTH-1:0] i_wdata;
    logic             i_flush;
    logic             o_busy;
    logic             o_done;
    logic [WIDTH-1:0] o_hi;
    logic [WIDTH-1:0] o_lo;

    modport master (
        output i_valid, i_div, i_sign, i_src1, i_src2,
        output i_hi_we, i_lo_we, i_wdata, i_flush,
        input  o_busy, o_done, o_hi, o_lo
    );

    modport slave (
        input  i_valid, i_div, i_sign, i_src1, i_src2,
        input  i_hi_we, i_lo_we, i_wdata, i_flush,
        output o_busy, o_done, o_hi, o_lo
    );
endinterface

// File: rtl/hilo_muldiv_unit.sv
// Iterative shift-add multiplier / restoring divider owning HI and LO.
// One bit per cycle; sign fix-up in a final cycle before HI/LO update.
module hilo_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    hilo_muldiv_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_FIX  = 2'd3;

    logic [1:0]         state;
    logic [CW-1:0]      cnt;
    logic               is_div;
    logic               s1;
    logic               s2;
    logic [WIDTH-1:0]   a;
    logic [2*WIDTH-1:0] p;
    logic [WIDTH:0]     r;
    logic [WIDTH-1:0]   hi;
    logic [WIDTH-1:0]   lo;
    logic               done;

    logic               neg1;
    logic               neg2;
    logic [WIDTH-1:0]   abs1;
    logic [WIDTH-1:0]   abs2;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] p_mul;
    logic [WIDTH:0]     r_sh;
    logic [WIDTH:0]     diff;
    logic               q_bit;
    logic [WIDTH:0]     r_div;
    logic [2*WIDTH-1:0] p_div;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic               last;

    // Operand magnitudes and the per-step mul/div datapath.
    always_comb begin
        neg1  = bus.i_sign & bus.i_src1[WIDTH-1];
        neg2  = bus.i_sign & bus.i_src2[WIDTH-1];
        abs1  = neg1 ? -bus.i_src1 : bus.i_src1;
        abs2  = neg2 ? -bus.i_src2 : bus.i_src2;
        sum   = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, a} : '0);
        p_mul = {sum, p[WIDTH-1:1]};
        r_sh  = {r[WIDTH-1:0], p[WIDTH-1]};
        diff  = r_sh - {1'b0, a};
        q_bit = ~diff[WIDTH];
        r_div = q_bit ? diff : r_sh;
        p_div = {p[2*WIDTH-1:WIDTH], p[WIDTH-2:0], q_bit};
        last  = (cnt == CW'(WIDTH - 1));
    end

    // Sign correction applied in the FIX cycle; divide by zero forces LO to all-ones.
    always_comb begin
        prod_fix = (s1 ^ s2) ? -p : p;
        if (a == '0)
            quo_fix = '1;
        else
            quo_fix = (s1 ^ s2) ? -p[WIDTH-1:0] : p[WIDTH-1:0];
        rem_fix = s1 ? -r[WIDTH-1:0] : r[WIDTH-1:0];
    end

    // Control FSM, iteration registers, HI/LO and the done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            cnt    <= '0;
            is_div <= 1'b0;
            s1     <= 1'b0;
            s2     <= 1'b0;
            a      <= '0;
            p      <= '0;
            r      <= '0;
            hi     <= '0;
            lo     <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (bus.i_hi_we) hi <= bus.i_wdata;
                    if (bus.i_lo_we) lo <= bus.i_wdata;
                    if (bus.i_valid && !bus.i_flush) begin
                        cnt    <= '0;
                        is_div <= bus.i_div;
                        s1     <= neg1;
                        s2     <= neg2;
                        r      <= '0;
                        a      <= bus.i_div ? abs2 : abs1;
                        p      <= {{WIDTH{1'b0}}, bus.i_div ? abs1 : abs2};
                        state  <= bus.i_div ? S_DIV : S_MUL;
                    end
                end
                S_MUL, S_DIV: begin
                    if (bus.i_flush) begin
                        state <= S_IDLE;
                    end else begin
                        if (state == S_MUL) begin
                            p <= p_mul;
                        end else begin
                            p <= p_div;
                            r <= r_div;
                        end
                        cnt <= cnt + 1'b1;
                        if (last) state <= S_FIX;
                    end
                end
                S_FIX: begin
                    state <= S_IDLE;
                    if (!bus.i_flush) begin
                        done <= 1'b1;
                        if (is_div) begin
                            hi <= rem_fix;
                            lo <= quo_fix;
                        end else begin
                            hi <= prod_fix[2*WIDTH-1:WIDTH];
                            lo <= prod_fix[WIDTH-1:0];
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.o_busy = (state != S_IDLE);
    assign bus.o_done = done;
    assign bus.o_hi   = hi;
    assign bus.o_lo   = lo;
endmodule
